// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad matrix responder: FSM states and the
// key-code to (row, column) mapping shared with the scanner decode.
package keypad_pkg;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      MAKE_BOUNCE  = 3'd1,
      HOLD         = 3'd2,
      BREAK_BOUNCE = 3'd3,
      GAP          = 3'd4
   } key_state_t;

   localparam int KEY_ROW_HI = 3;
   localparam int KEY_ROW_LO = 2;
   localparam int KEY_COL_HI = 1;
   localparam int KEY_COL_LO = 0;

   function automatic logic [1:0] key_row(input logic [3:0] key);
      return key[KEY_ROW_HI:KEY_ROW_LO];
   endfunction

   function automatic logic [1:0] key_col(input logic [3:0] key);
      return key[KEY_COL_HI:KEY_COL_LO];
   endfunction

   function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
      return {r, c};
   endfunction

endpackage

// File: rtl/keypad_bounce_gen.sv
// Contact chatter generator: holds the toggle counter and yields the contact
// level that a bounce state should present in the next cycle.
module keypad_bounce_gen
   import keypad_pkg::*;
#(
   parameter int BOUNCE_PERIOD = 8
) (
   input  logic clk,
   input  logic reset_n,
   input  logic start_s,
   input  logic start_level_s,
   input  logic run_s,
   output logic level_nxt_s
);

   localparam int TW = (BOUNCE_PERIOD > 1) ? $clog2(BOUNCE_PERIOD) : 1;
   localparam logic [TW-1:0] TOG_LAST = TW'(BOUNCE_PERIOD - 1);

   logic [TW-1:0] tog_cnt_r;
   logic [TW-1:0] tog_cnt_nxt_s;
   logic          phase_r;

   // Next chatter phase: restart on bounce entry, flip every BOUNCE_PERIOD cycles.
   always_comb begin
      tog_cnt_nxt_s = '0;
      level_nxt_s   = 1'b0;
      if (start_s) begin
         level_nxt_s   = start_level_s;
         tog_cnt_nxt_s = '0;
      end else if (run_s) begin
         if (tog_cnt_r == TOG_LAST) begin
            level_nxt_s   = ~phase_r;
            tog_cnt_nxt_s = '0;
         end else begin
            level_nxt_s   = phase_r;
            tog_cnt_nxt_s = tog_cnt_r + TW'(1);
         end
      end else begin
         level_nxt_s   = 1'b0;
         tog_cnt_nxt_s = '0;
      end
   end

   // Toggle counter and current chatter phase.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tog_cnt_r <= '0;
         phase_r   <= 1'b0;
      end else begin
         tog_cnt_r <= tog_cnt_nxt_s;
         phase_r   <= level_nxt_s;
      end
   end

endmodule

// File: rtl/keypad_matrix_responder.sv
// Switch-matrix model of a 4x4 keypad: presses one commanded key with make/break
// chatter and answers the scanner's column drive with row levels.
module keypad_matrix_responder
   import keypad_pkg::*;
#(
   parameter int BOUNCE_LEN    = 64,
   parameter int BOUNCE_PERIOD = 8,
   parameter int GAP_CYCLES    = 256,
   parameter int HOLD_W        = 24
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [3:0]        cmd_key,
   input  logic [HOLD_W-1:0] cmd_hold,
   input  logic [3:0]        col,
   output logic [3:0]        row,
   output logic              busy,
   output logic              done
);

   localparam int GAP_W = $clog2(GAP_CYCLES + 1);
   localparam int BL_W  = $clog2(BOUNCE_LEN + 1);
   localparam int CNT_A = (HOLD_W > GAP_W) ? HOLD_W : GAP_W;
   localparam int CNT_W = (CNT_A > BL_W) ? CNT_A : BL_W;

   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]  BL_LOAD  = CNT_W'(BOUNCE_LEN);
   localparam logic [CNT_W-1:0]  GAP_LOAD = CNT_W'(GAP_CYCLES);
   localparam logic [CNT_W-1:0]  PER_CNT  = CNT_W'(BOUNCE_PERIOD);
   localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
   localparam logic              HAS_BOUNCE = (BOUNCE_LEN > 0);

   key_state_t        state_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [1:0]        row_idx_r;
   logic [1:0]        col_idx_r;
   logic [HOLD_W-1:0] hold_r;
   logic              contact_r;
   logic              cmd_ready_r;
   logic              busy_r;
   logic              done_r;

   logic              accept_s;
   logic              last_s;
   logic              make_start_s;
   logic              break_start_s;
   logic              bounce_run_s;
   logic              bounce_level_s;
   logic [HOLD_W-1:0] hold_clamp_s;
   logic [3:0]        row_s;

   assign accept_s      = cmd_valid && cmd_ready_r;
   assign last_s        = (cnt_r == CNT_ONE);
   assign make_start_s  = accept_s && HAS_BOUNCE;
   assign break_start_s = (state_r == HOLD) && last_s && HAS_BOUNCE;
   assign bounce_run_s  = ((state_r == MAKE_BOUNCE) || (state_r == BREAK_BOUNCE)) && !last_s;

   keypad_bounce_gen #(
      .BOUNCE_PERIOD (BOUNCE_PERIOD)
   ) u_bounce (
      .clk           (clk),
      .reset_n       (reset_n),
      .start_s       (make_start_s || break_start_s),
      .start_level_s (make_start_s),
      .run_s         (bounce_run_s),
      .level_nxt_s   (bounce_level_s)
   );

   // A zero hold request still closes the contact for one cycle.
   always_comb begin
      hold_clamp_s = cmd_hold;
      if (cmd_hold == '0) begin
         hold_clamp_s = HOLD_ONE;
      end else begin
         hold_clamp_s = cmd_hold;
      end
   end

   // Press sequencer: one phase counter reloaded on every state entry, counting down to 1.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r     <= IDLE;
         cnt_r       <= '0;
         row_idx_r   <= 2'b00;
         col_idx_r   <= 2'b00;
         hold_r      <= '0;
         contact_r   <= 1'b0;
         cmd_ready_r <= 1'b1;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  row_idx_r   <= key_row(cmd_key);
                  col_idx_r   <= key_col(cmd_key);
                  hold_r      <= hold_clamp_s;
                  cmd_ready_r <= 1'b0;
                  busy_r      <= 1'b1;
                  contact_r   <= 1'b1;
                  if (HAS_BOUNCE) begin
                     state_r <= MAKE_BOUNCE;
                     cnt_r   <= BL_LOAD;
                  end else begin
                     state_r <= HOLD;
                     cnt_r   <= CNT_W'(hold_clamp_s);
                  end
               end
            end
            MAKE_BOUNCE: begin
               if (last_s) begin
                  state_r   <= HOLD;
                  cnt_r     <= CNT_W'(hold_r);
                  contact_r <= 1'b1;
               end else begin
                  cnt_r     <= cnt_r - CNT_ONE;
                  contact_r <= bounce_level_s;
               end
            end
            HOLD: begin
               if (last_s) begin
                  contact_r <= 1'b0;
                  if (HAS_BOUNCE) begin
                     state_r <= BREAK_BOUNCE;
                     cnt_r   <= BL_LOAD;
                  end else begin
                     state_r <= GAP;
                     cnt_r   <= GAP_LOAD;
                  end
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            BREAK_BOUNCE: begin
               if (last_s) begin
                  state_r   <= GAP;
                  cnt_r     <= GAP_LOAD;
                  contact_r <= 1'b0;
               end else begin
                  cnt_r     <= cnt_r - CNT_ONE;
                  // The last BOUNCE_PERIOD cycles of the break stay open.
                  contact_r <= bounce_level_s && ((cnt_r - CNT_ONE) > PER_CNT);
               end
            end
            GAP: begin
               if (last_s) begin
                  state_r     <= IDLE;
                  cnt_r       <= '0;
                  cmd_ready_r <= 1'b1;
                  busy_r      <= 1'b0;
                  done_r      <= 1'b1;
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            default: begin
               state_r     <= IDLE;
               cnt_r       <= '0;
               contact_r   <= 1'b0;
               cmd_ready_r <= 1'b1;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   // Row sense follows the column drive with no register, like a real switch.
   always_comb begin
      row_s = 4'b1111;
      if (contact_r && (col[col_idx_r] == 1'b0)) begin
         row_s[row_idx_r] = 1'b0;
      end else begin
         row_s = 4'b1111;
      end
   end

   assign row       = row_s;
   assign cmd_ready = cmd_ready_r;
   assign busy      = busy_r;
   assign done      = done_r;

endmodule

// File: tb/tb_keypad_matrix_responder.sv
// Self-checking bench: two responders (with and without bounce) checked every
// cycle against a timeline model, plus table vectors and a scanner loop.
module tb_keypad_matrix_responder;

   localparam int A_BL = 64, A_P = 8, A_GAP = 256;
   localparam int B_BL = 0,  B_P = 8, B_GAP = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic        va, ra, ba, da, vb, rb, bb, db;
   logic [3:0]  ka, cola, rowa, kb, colb, rowb;
   logic [23:0] ha, hb;

   keypad_matrix_responder #(.BOUNCE_LEN(A_BL), .BOUNCE_PERIOD(A_P), .GAP_CYCLES(A_GAP), .HOLD_W(24)) dut_a (
      .clk(clk), .reset_n(reset_n), .cmd_valid(va), .cmd_ready(ra), .cmd_key(ka), .cmd_hold(ha),
      .col(cola), .row(rowa), .busy(ba), .done(da));

   keypad_matrix_responder #(.BOUNCE_LEN(B_BL), .BOUNCE_PERIOD(B_P), .GAP_CYCLES(B_GAP), .HOLD_W(24)) dut_b (
      .clk(clk), .reset_n(reset_n), .cmd_valid(vb), .cmd_ready(rb), .cmd_key(kb), .cmd_hold(hb),
      .col(colb), .row(rowb), .busy(bb), .done(db));

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit         active;
      int         t;
      int         total;
      int         hold;
      logic [3:0] key;
      bit         done_exp;
   } model_t;

   typedef struct {
      logic [3:0]  key;
      logic [23:0] hold;
      logic [3:0]  col;
      logic [3:0]  row_on;
   } vec_t;

   model_t     ma, mb;
   logic [3:0] last_rowa;

   // Contact level t cycles after the accept edge, from the phase lengths alone.
   function automatic bit exp_contact(input int t, input int bl, input int p, input int hold);
      int i;
      if (t < 1) return 1'b0;
      if (t <= bl) return (((t - 1) / p) % 2) == 0;
      if (t <= bl + hold) return 1'b1;
      if (t <= 2 * bl + hold) begin
         i = t - bl - hold - 1;
         return (i < bl - p) && (((i / p) % 2) == 1);
      end
      return 1'b0;
   endfunction

   function automatic logic [3:0] exp_row(input bit contact, input logic [3:0] key, input logic [3:0] c);
      logic [3:0] r;
      r = 4'b1111;
      if (contact && c[key[1:0]] == 1'b0) r[key[3:2]] = 1'b0;
      return r;
   endfunction

   function automatic model_t step_model(input model_t m, input bit rst, input bit v,
                                         input logic [3:0] k, input logic [23:0] h,
                                         input int bl, input int gap);
      model_t n;
      n = m;
      n.done_exp = 1'b0;
      if (rst) begin
         n.active = 1'b0;
         n.t      = 0;
      end else if (v && !m.active) begin
         n.active = 1'b1;
         n.t      = 1;
         n.key    = k;
         n.hold   = (h == 24'd0) ? 1 : int'(h);
         n.total  = 2 * bl + n.hold + gap;
      end else if (m.active) begin
         n.t = m.t + 1;
         if (n.t > m.total) begin
            n.active   = 1'b0;
            n.done_exp = 1'b1;
         end
      end
      return n;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
      end
   endtask

   // Compare both DUTs with the model for the current cycle, then advance one clock.
   task automatic cycle();
      #1;
      chk("row_a",   rowa, exp_row(ma.active && exp_contact(ma.t, A_BL, A_P, ma.hold), ma.key, cola));
      chk("ready_a", ra,   !ma.active);
      chk("busy_a",  ba,   ma.active);
      chk("done_a",  da,   ma.done_exp);
      chk("row_b",   rowb, exp_row(mb.active && exp_contact(mb.t, B_BL, B_P, mb.hold), mb.key, colb));
      chk("ready_b", rb,   !mb.active);
      chk("busy_b",  bb,   mb.active);
      chk("done_b",  db,   mb.done_exp);
      last_rowa = rowa;
      @(posedge clk);
      ma = step_model(ma, !reset_n, va, ka, ha, A_BL, A_GAP);
      mb = step_model(mb, !reset_n, vb, kb, hb, B_BL, B_GAP);
      #1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vt[6];
      vt[0] = '{4'h9, 24'd10, 4'b1101, 4'b1011};
      vt[1] = '{4'h9, 24'd10, 4'b1110, 4'b1111};
      vt[2] = '{4'h6, 24'd3,  4'b1011, 4'b1101};
      vt[3] = '{4'hF, 24'd5,  4'b0111, 4'b0111};
      vt[4] = '{4'h0, 24'd4,  4'b0000, 4'b1110};
      vt[5] = '{4'h3, 24'd0,  4'b0111, 4'b1110};

      ma = '{active: 1'b0, t: 0, total: 0, hold: 1, key: 4'h0, done_exp: 1'b0};
      mb = ma;
      reset_n = 1'b0;
      va = 1'b0; ka = 4'h0; ha = 24'd0; cola = 4'b0000;
      vb = 1'b0; kb = 4'h0; hb = 24'd0; colb = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      cycle();
      chk("rst_row_a", rowa, 4'hF);
      chk("rst_ready_a", ra, 1'b1);
      chk("rst_busy_b", bb, 1'b0);
      chk("rst_done_b", db, 1'b0);
      reset_n = 1'b1;
      cycle();

      // Table vectors on the bounce-free responder.
      foreach (vt[i]) begin
         int hh;
         hh = (vt[i].hold == 24'd0) ? 1 : int'(vt[i].hold);
         vb = 1'b1; kb = vt[i].key; hb = vt[i].hold; colb = vt[i].col;
         cycle();
         vb = 1'b0;
         for (int c = 1; c <= hh + B_GAP + 1; c++) begin
            chk("tbl_row", rowb, (c <= hh) ? vt[i].row_on : 4'b1111);
            chk("tbl_done", db, (c == hh + B_GAP + 1));
            cycle();
         end
      end

      // Key 0 with full chatter: closed-cycle total and number of closures.
      begin
         int closed_n, closures;
         bit prev;
         closed_n = 0; closures = 0; prev = 1'b0;
         va = 1'b1; ka = 4'h0; ha = 24'd100; cola = 4'b1110;
         cycle();
         va = 1'b0;
         for (int c = 1; c <= 2 * A_BL + 100 + A_GAP; c++) begin
            if (!rowa[0]) closed_n++;
            if (!rowa[0] && !prev) closures++;
            prev = !rowa[0];
            cycle();
         end
         chk("wave_closed_cycles", closed_n, 156);
         chk("wave_closures", closures, 8);
         chk("wave_done", da, 1'b1);
         cycle();
      end

      // Reset in the middle of HOLD.
      va = 1'b1; ka = 4'h6; ha = 24'd200; cola = 4'b1011;
      cycle();
      va = 1'b0;
      repeat (100) cycle();
      chk("hold_row", rowa, 4'b1101);
      reset_n = 1'b0;
      cycle();
      reset_n = 1'b1;
      chk("rst_mid_row", rowa, 4'b1111);
      chk("rst_mid_busy", ba, 1'b0);
      chk("rst_mid_done", da, 1'b0);
      repeat (5) cycle();

      // cmd_valid held high with zero hold: accepts only in done cycles.
      begin
         int acc;
         acc = 0;
         vb = 1'b1; kb = 4'h5; hb = 24'd0; colb = 4'b1101;
         for (int c = 0; c < 54; c++) begin
            if (rb && vb) begin
               if (acc > 0) chk("b2b_done", db, 1'b1);
               acc++;
            end
            cycle();
         end
         chk("b2b_accepts", acc, 3);
         vb = 1'b0;
         for (int c = 0; c < 40 && mb.active; c++) cycle();
      end

      // Randomised traffic on both responders.
      for (int c = 0; c < 3000; c++) begin
         va = ($urandom_range(0, 9) == 0);
         ka = 4'($urandom);
         ha = 24'($urandom_range(0, 20));
         cola = ($urandom_range(0, 1) == 0) ? ~(4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
         vb = ($urandom_range(0, 3) == 0);
         kb = 4'($urandom);
         hb = 24'($urandom_range(0, 12));
         colb = ($urandom_range(0, 1) == 0) ? ~(4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
         cycle();
      end
      va = 1'b0; vb = 1'b0;
      for (int c = 0; c < 600 && (ma.active || mb.active); c++) cycle();
      chk("drain_idle_a", ra, 1'b1);

      // Scanner in the loop: every key once, one debounced event per press.
      for (int k = 0; k < 16; k++) begin
         int ev, code, sc, hits, hit_code, cand, stable, reported, budget;
         bit seen_done;
         ev = 0; code = -1; sc = 0; hits = 0; hit_code = 16;
         cand = 16; stable = 0; reported = 16; seen_done = 1'b0;
         budget = 2 * A_BL + 2000 + A_GAP + 4;
         va = 1'b1; ka = 4'(k); ha = 24'd2000;
         for (int c = 0; c < budget && !seen_done; c++) begin
            cola = ~(4'b0001 << sc);
            cycle();
            va = 1'b0;
            for (int r = 0; r < 4; r++) begin
               if (!last_rowa[r]) begin
                  hits++;
                  hit_code = r * 4 + sc;
               end
            end
            if (sc == 3) begin
               int scan_key;
               scan_key = (hits == 1) ? hit_code : ((hits == 0) ? 16 : 17);
               if (scan_key == cand) stable++;
               else begin
                  cand = scan_key;
                  stable = 1;
               end
               if (stable == 6 && cand != reported) begin
                  reported = cand;
                  if (cand < 16) begin
                     ev++;
                     code = cand;
                  end
               end
               hits = 0;
            end
            sc = (sc + 1) % 4;
            if (da) seen_done = 1'b1;
         end
         chk("scan_done_seen", seen_done, 1'b1);
         chk("scan_events", ev, 1);
         chk("scan_code", code, k);
         chk("scan_released", reported, 16);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
